// File: rtl/axi_lite_xbar_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_xbar_cfg_ctrl_if
// Brief    : Request channel, slave-port handshake taps and active crossbar
//            configuration of the run-time crossbar configuration sequencer.
//            Macro AXI_LITE_XBAR_CFG_TIMEOUT_EN adds cfg_err_o.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_xbar_cfg_ctrl_if #(
    parameter int unsigned NoSlvPorts  = 2,
    parameter int unsigned NoMstPorts  = 4,
    parameter int unsigned NoAddrRules = 4,
    parameter type         rule_t      = struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    },
    parameter int unsigned MstIdxWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
);
    logic                                   cfg_valid_i;
    logic                                   cfg_ready_o;
    rule_t [NoAddrRules-1:0]                cfg_addr_map_i;
    logic  [NoSlvPorts-1:0]                 cfg_en_default_i;
    logic  [NoSlvPorts-1:0][MstIdxWidth-1:0] cfg_default_i;
    logic                                   cfg_done_o;
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
    logic                                   cfg_err_o;
`endif

    logic  [NoSlvPorts-1:0]                 slv_aw_valid_i;
    logic  [NoSlvPorts-1:0]                 slv_aw_ready_i;
    logic  [NoSlvPorts-1:0]                 slv_b_valid_i;
    logic  [NoSlvPorts-1:0]                 slv_b_ready_i;
    logic  [NoSlvPorts-1:0]                 slv_ar_valid_i;
    logic  [NoSlvPorts-1:0]                 slv_ar_ready_i;
    logic  [NoSlvPorts-1:0]                 slv_r_valid_i;
    logic  [NoSlvPorts-1:0]                 slv_r_ready_i;
    logic  [NoSlvPorts-1:0]                 aw_block_o;
    logic  [NoSlvPorts-1:0]                 ar_block_o;

    rule_t [NoAddrRules-1:0]                addr_map_o;
    logic  [NoSlvPorts-1:0]                 en_default_mst_port_o;
    logic  [NoSlvPorts-1:0][MstIdxWidth-1:0] default_mst_port_o;
    logic                                   busy_o;

    // Controller side
    modport slave (
        input  cfg_valid_i, cfg_addr_map_i, cfg_en_default_i, cfg_default_i,
               slv_aw_valid_i, slv_aw_ready_i, slv_b_valid_i, slv_b_ready_i,
               slv_ar_valid_i, slv_ar_ready_i, slv_r_valid_i, slv_r_ready_i,
        output cfg_ready_o, cfg_done_o, aw_block_o, ar_block_o,
               addr_map_o, en_default_mst_port_o, default_mst_port_o, busy_o
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
             , cfg_err_o
`endif
    );

    // Requester / integrator side
    modport master (
        output cfg_valid_i, cfg_addr_map_i, cfg_en_default_i, cfg_default_i,
               slv_aw_valid_i, slv_aw_ready_i, slv_b_valid_i, slv_b_ready_i,
               slv_ar_valid_i, slv_ar_ready_i, slv_r_valid_i, slv_r_ready_i,
        input  cfg_ready_o, cfg_done_o, aw_block_o, ar_block_o,
               addr_map_o, en_default_mst_port_o, default_mst_port_o, busy_o
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
             , cfg_err_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_xbar_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_xbar_cfg_ctrl
// Brief    : Blocks new AW/AR, drains outstanding transactions and swaps the
//            crossbar configuration atomically while the crossbar is idle.
//            Macro AXI_LITE_XBAR_CFG_TIMEOUT_EN enables the drain timeout.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_xbar_cfg_ctrl #(
    parameter int unsigned NoSlvPorts    = 2,
    parameter int unsigned NoMstPorts    = 4,
    parameter int unsigned NoAddrRules   = 4,
    parameter type         rule_t        = struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    },
    parameter int unsigned MaxTrans      = 8,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned MstIdxWidth   = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    axi_lite_xbar_cfg_ctrl_if.slave   bus
);
    localparam int unsigned              C_CNT_WIDTH = $clog2(MaxTrans + 1);
    localparam logic [C_CNT_WIDTH-1:0]   C_CNT_MAX   = C_CNT_WIDTH'(MaxTrans);
    localparam logic [C_CNT_WIDTH-1:0]   C_CNT_ONE   = C_CNT_WIDTH'(1);

    if ((MaxTrans == 0) || (TimeoutCycles == 0)) begin : g_param_check
        $error("MaxTrans and TimeoutCycles must be non-zero");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BLOCK   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_SWAP    = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    state_e                                  state_q, state_d;
    logic [NoSlvPorts-1:0][C_CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [NoSlvPorts-1:0][C_CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [NoSlvPorts-1:0]                   aw_pend_q, aw_pend_d;
    logic [NoSlvPorts-1:0]                   ar_pend_q, ar_pend_d;

    rule_t [NoAddrRules-1:0]                 sh_map_q, sh_map_d;
    logic  [NoSlvPorts-1:0]                  sh_en_q, sh_en_d;
    logic  [NoSlvPorts-1:0][MstIdxWidth-1:0] sh_def_q, sh_def_d;
    rule_t [NoAddrRules-1:0]                 map_q, map_d;
    logic  [NoSlvPorts-1:0]                  en_q, en_d;
    logic  [NoSlvPorts-1:0][MstIdxWidth-1:0] def_q, def_d;

    logic                  blocking;
    logic                  cfg_ready;
    logic                  cfg_done;
    logic [NoSlvPorts-1:0] aw_block, ar_block;
    logic [NoSlvPorts-1:0] aw_hs, b_hs, ar_hs, r_hs;

`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TimeoutCycles - 1);
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        abort_q, abort_d;
    logic        cfg_err;
`endif

    assign aw_hs = bus.slv_aw_valid_i & bus.slv_aw_ready_i;
    assign b_hs  = bus.slv_b_valid_i  & bus.slv_b_ready_i;
    assign ar_hs = bus.slv_ar_valid_i & bus.slv_ar_ready_i;
    assign r_hs  = bus.slv_r_valid_i  & bus.slv_r_ready_i;

    // A beat stays pending only while valid is held without ready
    assign aw_pend_d = bus.slv_aw_valid_i & ~bus.slv_aw_ready_i;
    assign ar_pend_d = bus.slv_ar_valid_i & ~bus.slv_ar_ready_i;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        for (int i = 0; i < NoSlvPorts; i++) begin
            if (aw_hs[i] && !b_hs[i]) begin
                wr_cnt_d[i] = wr_cnt_q[i] + C_CNT_ONE;
            end else if (!aw_hs[i] && b_hs[i]) begin
                wr_cnt_d[i] = wr_cnt_q[i] - C_CNT_ONE;
            end
            if (ar_hs[i] && !r_hs[i]) begin
                rd_cnt_d[i] = rd_cnt_q[i] + C_CNT_ONE;
            end else if (!ar_hs[i] && r_hs[i]) begin
                rd_cnt_d[i] = rd_cnt_q[i] - C_CNT_ONE;
            end
        end
    end

    // The flow limit applies in every state so the counters cannot wrap
    always_comb begin
        aw_block = '0;
        ar_block = '0;
        for (int i = 0; i < NoSlvPorts; i++) begin
            aw_block[i] = (blocking && !aw_pend_q[i]) || (wr_cnt_q[i] == C_CNT_MAX);
            ar_block[i] = (blocking && !ar_pend_q[i]) || (rd_cnt_q[i] == C_CNT_MAX);
        end
    end

    always_comb begin
        state_d   = state_q;
        blocking  = 1'b0;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        sh_map_d  = sh_map_q;
        sh_en_d   = sh_en_q;
        sh_def_d  = sh_def_q;
        map_d     = map_q;
        en_d      = en_q;
        def_d     = def_q;
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
        to_cnt_d  = 16'd0;
        abort_d   = abort_q;
        cfg_err   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (bus.cfg_valid_i) begin
                    sh_map_d = bus.cfg_addr_map_i;
                    sh_en_d  = bus.cfg_en_default_i;
                    sh_def_d = bus.cfg_default_i;
                    state_d  = ST_BLOCK;
                end
            end
            ST_BLOCK: begin
                blocking = 1'b1;
                if (!(|aw_pend_q) && !(|ar_pend_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                blocking = 1'b1;
                if (!(|wr_cnt_q) && !(|rd_cnt_q)) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                blocking = 1'b1;
                map_d    = sh_map_q;
                en_d     = sh_en_q;
                def_d    = sh_def_q;
                state_d  = ST_RELEASE;
            end
            ST_RELEASE: begin
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
                cfg_done = !abort_q;
                cfg_err  = abort_q;
                abort_d  = 1'b0;
`else
                cfg_done = 1'b1;
`endif
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
        // Normal progress wins over a timeout expiring in the same cycle
        if ((state_q == ST_BLOCK) || (state_q == ST_DRAIN)) begin
            to_cnt_d = to_cnt_q + 16'd1;
            if ((state_d == state_q) && (to_cnt_q >= C_TIMEOUT_LAST)) begin
                state_d = ST_RELEASE;
                abort_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            aw_pend_q <= '0;
            ar_pend_q <= '0;
            sh_map_q  <= '0;
            sh_en_q   <= '0;
            sh_def_q  <= '0;
            map_q     <= '0;
            en_q      <= '0;
            def_q     <= '0;
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
            to_cnt_q  <= 16'd0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            aw_pend_q <= aw_pend_d;
            ar_pend_q <= ar_pend_d;
            sh_map_q  <= sh_map_d;
            sh_en_q   <= sh_en_d;
            sh_def_q  <= sh_def_d;
            map_q     <= map_d;
            en_q      <= en_d;
            def_q     <= def_d;
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            abort_q   <= abort_d;
`endif
        end
    end

    assign bus.cfg_ready_o           = cfg_ready;
    assign bus.cfg_done_o            = cfg_done;
    assign bus.aw_block_o            = aw_block;
    assign bus.ar_block_o            = ar_block;
    assign bus.addr_map_o            = map_q;
    assign bus.en_default_mst_port_o = en_q;
    assign bus.default_mst_port_o    = def_q;
    assign bus.busy_o                = (state_q != ST_IDLE);
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
    assign bus.cfg_err_o             = cfg_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_xbar_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_xbar_cfg_ctrl
// Brief    : Directed bench for the crossbar configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_xbar_cfg_ctrl;
    localparam int unsigned NSP  = 2;
    localparam int unsigned NMP  = 4;
    localparam int unsigned NAR  = 4;
    localparam int unsigned MAXT = 8;
    localparam int unsigned MIW  = 2;
    localparam int unsigned RW   = 96;
`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
    localparam int unsigned TOC  = 16;
`else
    localparam int unsigned TOC  = 1024;
`endif
    localparam int unsigned MAPW = NAR * RW;
    localparam int unsigned CFGW = MAPW + NSP + NSP * MIW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_xbar_cfg_ctrl_if #(
        .NoSlvPorts(NSP), .NoMstPorts(NMP), .NoAddrRules(NAR)
    ) bus ();

    axi_lite_xbar_cfg_ctrl #(
        .NoSlvPorts(NSP), .NoMstPorts(NMP), .NoAddrRules(NAR),
        .MaxTrans(MAXT), .TimeoutCycles(TOC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic            cfg_valid;
        logic [1:0]      aw, b, ar, r;
        logic [1:0]      e_awb, e_arb;
        logic            e_ready, e_busy, e_done;
        logic [CFGW-1:0] e_cfg;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    logic [CFGW-1:0] cfg_zero, cfg_a, cfg_b, cfg_c;

    function automatic logic [RW-1:0] rule(input logic [31:0] idx, input logic [31:0] s,
                                            input logic [31:0] e);
        return {idx, s, e};
    endfunction

    function automatic logic [CFGW-1:0] active_cfg();
        return {bus.addr_map_o, bus.en_default_mst_port_o, bus.default_mst_port_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cfg(input logic [CFGW-1:0] c);
        bus.cfg_addr_map_i   = c[CFGW-1 -: MAPW];
        bus.cfg_en_default_i = c[NSP*MIW +: NSP];
        bus.cfg_default_i    = c[NSP*MIW-1:0];
    endtask

    // Handshake masks: valid and ready both driven with the mask
    task automatic set_hs(input logic [1:0] aw, input logic [1:0] b,
                          input logic [1:0] ar, input logic [1:0] r);
        bus.slv_aw_valid_i = aw; bus.slv_aw_ready_i = aw;
        bus.slv_b_valid_i  = b;  bus.slv_b_ready_i  = b;
        bus.slv_ar_valid_i = ar; bus.slv_ar_ready_i = ar;
        bus.slv_r_valid_i  = r;  bus.slv_r_ready_i  = r;
    endtask

    task automatic add(input logic cv, input logic [1:0] aw, input logic [1:0] b,
                       input logic [1:0] ar, input logic [1:0] r,
                       input logic [1:0] eawb, input logic [1:0] earb,
                       input logic erdy, input logic ebusy, input logic edone,
                       input logic [CFGW-1:0] ecfg);
        vecs[nv].cfg_valid = cv;
        vecs[nv].aw = aw; vecs[nv].b = b; vecs[nv].ar = ar; vecs[nv].r = r;
        vecs[nv].e_awb = eawb; vecs[nv].e_arb = earb;
        vecs[nv].e_ready = erdy; vecs[nv].e_busy = ebusy; vecs[nv].e_done = edone;
        vecs[nv].e_cfg = ecfg;
        nv++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        cfg_zero = '0;
        cfg_a = {rule(0, 0, 0), rule(0, 0, 0), rule(0, 0, 0),
                 rule(32'd1, 32'h0000_0000, 32'h0000_1000), 2'b01, 2'd3, 2'd1};
        cfg_b = {rule(0, 0, 0), rule(0, 0, 0), rule(32'd2, 32'h0000_1000, 32'h0000_2000),
                 rule(32'd3, 32'h0000_0000, 32'h0000_1000), 2'b11, 2'd2, 2'd0};
        cfg_c = {rule(32'd1, 32'h8000_0000, 32'h9000_0000), rule(0, 0, 0), rule(0, 0, 0),
                 rule(32'd0, 32'h0000_0000, 32'h0000_0100), 2'b10, 2'd1, 2'd2};

        bus.cfg_valid_i = 1'b0;
        drive_cfg(cfg_zero);
        set_hs(2'b00, 2'b00, 2'b00, 2'b00);

        // Reset state
        tick(); tick();
        chk("rst busy",   512'(bus.busy_o), 512'(1'b0));
        chk("rst done",   512'(bus.cfg_done_o), 512'(1'b0));
        chk("rst blocks", 512'({bus.aw_block_o, bus.ar_block_o}), 512'(4'b0000));
        chk("rst cfg",    512'(active_cfg()), 512'(cfg_zero));
        rst = 1'b0;
        tick();
        chk("rst ready",  512'(bus.cfg_ready_o), 512'(1'b1));

        // Quiescent swap latency
        add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, cfg_zero);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, cfg_zero);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, cfg_zero);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, cfg_a);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, cfg_a);
        // Write flow limit on port 1, then simultaneous AW+B at the limit
        for (int k = 1; k <= 8; k++)
            add(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, (k == 8) ? 2'b10 : 2'b00, 2'b00,
                1'b1, 1'b0, 1'b0, cfg_a);
        add(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, cfg_a);
        for (int k = 0; k < 8; k++)
            add(1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, cfg_a);
        // Read flow limit on port 0
        for (int k = 1; k <= 8; k++)
            add(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, (k == 8) ? 2'b01 : 2'b00,
                1'b1, 1'b0, 1'b0, cfg_a);
        add(1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, cfg_a);
        for (int k = 0; k < 8; k++)
            add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, cfg_a);

        drive_cfg(cfg_a);
        for (int i = 0; i < nv; i++) begin
            bus.cfg_valid_i = vecs[i].cfg_valid;
            set_hs(vecs[i].aw, vecs[i].b, vecs[i].ar, vecs[i].r);
            tick();
            chk($sformatf("vec%0d aw_block", i), 512'(bus.aw_block_o), 512'(vecs[i].e_awb));
            chk($sformatf("vec%0d ar_block", i), 512'(bus.ar_block_o), 512'(vecs[i].e_arb));
            chk($sformatf("vec%0d ready", i), 512'(bus.cfg_ready_o), 512'(vecs[i].e_ready));
            chk($sformatf("vec%0d busy", i), 512'(bus.busy_o), 512'(vecs[i].e_busy));
            chk($sformatf("vec%0d done", i), 512'(bus.cfg_done_o), 512'(vecs[i].e_done));
            chk($sformatf("vec%0d cfg", i), 512'(active_cfg()), 512'(vecs[i].e_cfg));
        end
        bus.cfg_valid_i = 1'b0;
        set_hs(2'b00, 2'b00, 2'b00, 2'b00);
        tick();

        // Three outstanding writes on port 0, B at cycles 5, 7, 9
        set_hs(2'b01, 2'b00, 2'b00, 2'b00);
        tick(); tick(); tick();
        set_hs(2'b00, 2'b00, 2'b00, 2'b00);
        drive_cfg(cfg_b);
        bus.cfg_valid_i = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            bus.cfg_valid_i = 1'b0;
            set_hs(2'b00, (c == 5 || c == 7 || c == 9) ? 2'b01 : 2'b00, 2'b00, 2'b00);
            chk($sformatf("drain c%0d aw_block", c), 512'(bus.aw_block_o),
                512'((c <= 11) ? 2'b11 : 2'b00));
            chk($sformatf("drain c%0d done", c), 512'(bus.cfg_done_o), 512'(c == 12));
            chk($sformatf("drain c%0d cfg", c), 512'(active_cfg()),
                512'((c >= 12) ? cfg_b : cfg_a));
        end
        tick();
        chk("drain idle ready", 512'(bus.cfg_ready_o), 512'(1'b1));

        // AW beat pending when the request is accepted must not be withdrawn
        drive_cfg(cfg_c);
        bus.cfg_valid_i    = 1'b1;
        bus.slv_aw_valid_i = 2'b01;
        bus.slv_aw_ready_i = 2'b00;
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.cfg_valid_i = 1'b0;
            if (c == 3) bus.slv_aw_ready_i = 2'b01;
            if (c == 4) begin
                bus.slv_aw_valid_i = 2'b00;
                bus.slv_aw_ready_i = 2'b00;
            end
            bus.slv_b_valid_i = (c == 6) ? 2'b01 : 2'b00;
            bus.slv_b_ready_i = (c == 6) ? 2'b01 : 2'b00;
            chk($sformatf("pend c%0d aw_block", c), 512'(bus.aw_block_o),
                512'({(c <= 8) ? 1'b1 : 1'b0, (c >= 4 && c <= 8) ? 1'b1 : 1'b0}));
            chk($sformatf("pend c%0d done", c), 512'(bus.cfg_done_o), 512'(c == 9));
            chk($sformatf("pend c%0d cfg", c), 512'(active_cfg()),
                512'((c >= 9) ? cfg_c : cfg_b));
        end
        tick();

        // Reset while draining an outstanding read on port 1
        set_hs(2'b00, 2'b00, 2'b10, 2'b00);
        tick();
        set_hs(2'b00, 2'b00, 2'b00, 2'b00);
        drive_cfg(cfg_a);
        bus.cfg_valid_i = 1'b1;
        tick();
        bus.cfg_valid_i = 1'b0;
        tick(); tick();
        chk("rstmid busy before", 512'(bus.busy_o), 512'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid busy", 512'(bus.busy_o), 512'(1'b0));
        chk("rstmid ready", 512'(bus.cfg_ready_o), 512'(1'b1));
        chk("rstmid blocks", 512'({bus.aw_block_o, bus.ar_block_o}), 512'(4'b0000));
        chk("rstmid cfg", 512'(active_cfg()), 512'(cfg_zero));
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("rstmid c%0d done", c), 512'(bus.cfg_done_o), 512'(1'b0));
            tick();
        end

`ifdef AXI_LITE_XBAR_CFG_TIMEOUT_EN
        // A read that never completes on port 0 forces a timeout release
        set_hs(2'b00, 2'b00, 2'b01, 2'b00);
        tick();
        set_hs(2'b00, 2'b00, 2'b00, 2'b00);
        drive_cfg(cfg_b);
        bus.cfg_valid_i = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            bus.cfg_valid_i = 1'b0;
            chk($sformatf("tmo c%0d err", c), 512'(bus.cfg_err_o), 512'(c == 17));
            chk($sformatf("tmo c%0d done", c), 512'(bus.cfg_done_o), 512'(1'b0));
            chk($sformatf("tmo c%0d ar_block", c), 512'(bus.ar_block_o),
                512'((c <= 16) ? 2'b11 : 2'b00));
            chk($sformatf("tmo c%0d cfg", c), 512'(active_cfg()), 512'(cfg_zero));
        end
        chk("tmo idle busy", 512'(bus.busy_o), 512'(1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
